// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver with 3-sample majority vote, parity/framing
// checks and a DEPTH-entry valid/ready FIFO. Optional line-break detect: UART_BREAK_DETECT_EN.
module uart_rx_fifo #(
  parameter int OVS_DIV = 27,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_ready,
  input  logic       overrun_clr,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       rts_n,
  output logic       break_det
);
  localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    hist_q;
  logic [2:0]    window;
  logic          maj, decide, last_bit, ferr_now;

  state_e     state_q, state_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_idx_q, stop_idx_d;
  logic [7:0] data_q, data_d;
  logic       par_acc_q, par_acc_d;
  logic       perr_q, perr_d, ferr_q, ferr_d;
  logic [1:0] dbn_q, dbn_d;
  logic       sbn_q, sbn_d, pen_q, pen_d, ptype_q, ptype_d;
  logic       push_q, push_d;
  logic [9:0] push_word_q, push_word_d;
`ifdef UART_BREAK_DETECT_EN
  logic       par_bit_q, par_bit_d, brk_q, brk_d, brk_frame;
`endif

  // Front end: synchroniser, oversample tick and the two older samples of the vote window.
  // NOTE: every register below is written with <=, so all of them see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
      hist_q     <= 2'b11;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      if (tick) begin
        tick_cnt_q <= '0;
        hist_q     <= {hist_q[0], rx_s_q};
      end else begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
      end
    end
  end

  assign tick     = (tick_cnt_q == TW'(OVS_DIV - 1));
  assign window   = {hist_q, rx_s_q};
  assign maj      = (window[2] & window[1]) | (window[2] & window[0]) | (window[1] & window[0]);
  assign decide   = tick && (samp_q == 4'd8);
  assign last_bit = (bit_q == ({1'b0, dbn_q} + 3'd4));
  assign ferr_now = ferr_q | ~maj;
`ifdef UART_BREAK_DETECT_EN
  assign brk_frame = ~maj & (data_q == 8'h00) & ~(pen_q & par_bit_q);
`endif

  // NOTE: every _d gets its default first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    stop_idx_d  = stop_idx_q;
    data_d      = data_q;
    par_acc_d   = par_acc_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    dbn_d       = dbn_q;
    sbn_d       = sbn_q;
    pen_d       = pen_q;
    ptype_d     = ptype_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
`ifdef UART_BREAK_DETECT_EN
    par_bit_d   = par_bit_q;
    brk_d       = 1'b0;
`endif
    if (tick && state_q != S_IDLE) samp_d = samp_q + 4'd1;
    unique case (state_q)
      S_IDLE: if (tick && !rx_s_q) begin
        samp_d  = 4'd0;
        dbn_d   = data_bit_num;
        sbn_d   = stop_bit_num;
        pen_d   = parity_en;
        ptype_d = parity_type;
        state_d = S_START;
      end
      S_START: if (decide) begin
        if (maj) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          bit_d     = 3'd0;
          data_d    = 8'h00;
          par_acc_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
`ifdef UART_BREAK_DETECT_EN
          par_bit_d = 1'b0;
`endif
        end
      end
      S_DATA: if (decide) begin
        data_d[bit_q] = maj;
        par_acc_d     = par_acc_q ^ maj;
        if (last_bit) begin
          state_d    = pen_q ? S_PARITY : S_STOP;
          stop_idx_d = 1'b0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_PARITY: if (decide) begin
        // Even parity wants the total XOR to be 0, odd wants 1.
        perr_d  = ((par_acc_q ^ maj) != ~ptype_q);
`ifdef UART_BREAK_DETECT_EN
        par_bit_d = maj;
`endif
        state_d = S_STOP;
      end
      S_STOP: if (decide) begin
`ifdef UART_BREAK_DETECT_EN
        if (!stop_idx_q && brk_frame) begin
          brk_d   = 1'b1;
          state_d = S_WAIT_HIGH;
        end else
`endif
        if (stop_idx_q == sbn_q) begin
          push_d      = 1'b1;
          push_word_d = {ferr_now, perr_q, data_q};
          state_d     = (ferr_now || perr_q) ? S_WAIT_HIGH : S_IDLE;
        end else begin
          stop_idx_d = 1'b1;
          ferr_d     = ferr_now;
        end
      end
      S_WAIT_HIGH: if (tick && rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      samp_q      <= '0;
      bit_q       <= '0;
      stop_idx_q  <= 1'b0;
      data_q      <= '0;
      par_acc_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      dbn_q       <= '0;
      sbn_q       <= 1'b0;
      pen_q       <= 1'b0;
      ptype_q     <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
`ifdef UART_BREAK_DETECT_EN
      par_bit_q   <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      stop_idx_q  <= stop_idx_d;
      data_q      <= data_d;
      par_acc_q   <= par_acc_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      dbn_q       <= dbn_d;
      sbn_q       <= sbn_d;
      pen_q       <= pen_d;
      ptype_q     <= ptype_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
`ifdef UART_BREAK_DETECT_EN
      par_bit_q   <= par_bit_d;
      brk_q       <= brk_d;
`endif
    end
  end

`ifdef UART_BREAK_DETECT_EN
  assign break_det = brk_q;
`else
  assign break_det = 1'b0;
`endif

  // Receive FIFO: entry = {frame_error, parity_error, data}.
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, rts_q, full, pop, wr_en;
  logic [9:0]    head;

  assign full     = (cnt_q == CW'(DEPTH));
  assign rx_valid = (cnt_q != '0);
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push_q & (~full | pop);
  assign cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);

  // NOTE: storage has no reset; rx_valid masks whatever the array holds after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_word_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      rts_q     <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      rts_q <= (cnt_d >= CW'(DEPTH - 2));
      if (push_q && full && !pop) overrun_q <= 1'b1;
      else if (overrun_clr)       overrun_q <= 1'b0;
    end
  end

  assign head = rx_valid ? mem_q[rd_q] : 10'd0;
  assign {frame_error, parity_error, rx_data} = head;
  assign overrun = overrun_q;
  assign rts_n   = rts_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Standalone UART receiver with a 16x-oversampled front end, majority-vote bit sampling, parity and framing checks, and a DEPTH-entry receive FIFO with a valid/ready read port.
- It is the receive end of the serial link driven by the team's UART transmitter; it uses the same frame-format inputs.
- It sits between the external rx pin and the host/bus logic, and drives rts_n for hardware flow control.

Parameters:
OVS_DIV, 27, clk cycles per oversample tick (one bit = 16 ticks = 16*OVS_DIV clk)
DEPTH, 8, FIFO entries (power of 2, >= 4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  serial input, idle high, asynchronous to clk
data_bit_num  in  2  00=5, 01=6, 10=7, 11=8 data bits
stop_bit_num  in  1  0=1 stop bit, 1=2 stop bits
parity_en  in  1  1=parity bit present
parity_type  in  1  1=even, 0=odd
rx_ready  in  1  consumer accepts head entry
overrun_clr  in  1  one-cycle pulse, clears overrun
rx_valid  out  1  FIFO non-empty
rx_data  out  8  head data, zero-extended above data_bit_num
parity_error  out  1  head entry parity flag
frame_error  out  1  head entry framing flag
overrun  out  1  sticky, frame dropped because FIFO full
rts_n  out  1  0 = ready to receive; 1 when fill >= DEPTH-2
break_det  out  1  one-cycle pulse on line break

Behaviour:
- Reset (async, active-high): FIFO empty; rx_valid=0, rx_data=0, parity_error=0, frame_error=0, overrun=0, rts_n=0, break_det=0. FSM goes to IDLE, tick counter=0, rx synchroniser=1.
- rx passes through a 2-FF synchroniser (rx_s). Tick counter runs 0..OVS_DIV-1 and asserts tick when the count equals OVS_DIV-1.
- Sampling: on each tick, a 3-bit history of rx_s is updated. A bit is decided at sample count 8 of the 16 ticks, by majority of the samples at ticks 6, 7, 8.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on a tick with rx_s=0, reset the sample count, latch all four config inputs, go to START. Config changes mid-frame have no effect.
  - START: at the decision point, majority=1 is a false start and returns to IDLE with nothing pushed. Otherwise go to DATA.
  - DATA: N bits, LSB first, with N from the latched data_bit_num. Running XOR is accumulated. After bit N, go to PARITY if parity_en, else STOP.
  - PARITY: parity_error = (XOR of data ^ parity bit) != (parity_type ? 0 : 1).
  - STOP: each stop bit must be 1; any 0 sets frame_error. At the decision point of the last stop bit, push {frame_error, parity_error, data} on the next clk edge. Then go to IDLE if the frame was clean, else to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick samples rx_s=1, then go to IDLE.
- Receive latency: rx_valid rises 2 clk after the last stop-bit decision tick when the FIFO was empty.
- FIFO:
  - rx_data and the flags show the head entry and read 0 when empty.
  - Pop occurs when rx_valid && rx_ready.
  - Push when full: the frame is dropped and overrun is set. It stays set until overrun_clr; if overrun_clr and a drop occur in the same cycle, set wins.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- rts_n is registered from the post-update fill count.
- Reset mid-frame aborts the frame; nothing is pushed.

Optional Feature:
- Macro UART_BREAK_DETECT_EN.
- Defined: a frame with all data bits 0, parity bit 0 (if enabled) and first stop bit 0 produces a one-cycle break_det pulse at the stop decision. Nothing is pushed, and the FSM enters WAIT_HIGH.
- Undefined: break_det is tied 0. The same frame is pushed as data 0x00 with frame_error=1, and the FSM enters WAIT_HIGH.

Test Plan:
- 8N1 (data_bit_num=11, stop=0, parity_en=0): send 0xA5 at 432 clk/bit, rx_ready=1 -> one pop with rx_data=0xA5, parity_error=0, frame_error=0.
- 7 bits, even parity, 2 stop bits: send 0x35 with the parity bit flipped -> rx_data=0x35, parity_error=1. Resend with correct parity -> parity_error=0.
- 5 bits: send 0x1F with the stop bit forced low -> rx_data=0x1F, frame_error=1. The next start is not accepted until rx has been high for at least 1 tick.
- rx_ready=0, send 9 frames 0x01..0x09 (DEPTH=8) -> rts_n=1 after the 6th push, overrun=1 after the 9th. Popping gives 0x01..0x08. overrun_clr -> overrun=0.
- 150-clk low glitch on idle rx (under 8 ticks) -> no push, rx_valid stays 0. Assert reset mid-DATA -> all outputs return to reset values, nothing is pushed.
- With UART_BREAK_DETECT_EN: hold rx low for 20 bit times -> exactly one break_det pulse, no FIFO push. After rx returns high, a subsequent 0x55 is received correctly.
